// File: rtl/dtw_axis_sample_unpacker_pkg.sv
// rtl/dtw_axis_sample_unpacker_pkg.sv - shared types, status bit indices and width helper
package dtw_axis_sample_unpacker_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_UNPACK = 1'b1
    } state_e;

    localparam int STAT_PARTIAL_LANE = 0;
    localparam int STAT_NULL_LAST    = 1;

    function automatic int clogb2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dtw_sample_fifo.sv
// rtl/dtw_sample_fifo.sv - first-word-fall-through sample FIFO with occupancy and almost-full
module dtw_sample_fifo
    import dtw_axis_sample_unpacker_pkg::*;
#(
    parameter int WIDTH     = 9,
    parameter int DEPTH     = 16,
    parameter int AF_MARGIN = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        wr_en_i,
    input  logic [WIDTH-1:0]            wr_data_i,
    input  logic                        rd_en_i,
    output logic [WIDTH-1:0]            rd_data_o,
    output logic                        empty_o,
    output logic                        full_o,
    output logic [clogb2(DEPTH+1)-1:0]  count_o,
    output logic                        afull_o
);

    localparam int PTR_W = clogb2(DEPTH);
    localparam int CNT_W = clogb2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_wr, do_rd;

    // Full/empty come from the registered count only: no bypass in either direction.
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign do_wr   = wr_en_i && !full_o;
    assign do_rd   = rd_en_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_rd) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];
    assign count_o   = count_q;
    assign afull_o   = ((CNT_W'(DEPTH) - count_q) <= CNT_W'(AF_MARGIN));

endmodule

// File: rtl/dtw_axis_sample_unpacker.sv
// rtl/dtw_axis_sample_unpacker.sv - AXI-Stream sink unpacking wide beats into a sample FIFO
module dtw_axis_sample_unpacker
    import dtw_axis_sample_unpacker_pkg::*;
#(
    parameter int C_S_AXIS_TDATA_WIDTH = 32,
    parameter int SAMPLE_WIDTH         = 8,
    parameter int FIFO_DEPTH           = 16,
    parameter int ALMOST_FULL_MARGIN   = 2
) (
    input  logic                                 S_AXIS_ACLK,
    input  logic                                 S_AXIS_ARESET,
    input  logic                                 S_AXIS_TVALID,
    output logic                                 S_AXIS_TREADY,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]      S_AXIS_TDATA,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0]    S_AXIS_TSTRB,
    input  logic                                 S_AXIS_TLAST,
    input  logic                                 dtw_fifo_rden,
    output logic [SAMPLE_WIDTH-1:0]              dtw_fifo_dout,
    output logic                                 dtw_fifo_last,
    output logic                                 dtw_fifo_empty,
    output logic [clogb2(FIFO_DEPTH+1)-1:0]      dtw_fifo_count,
    output logic                                 dtw_fifo_afull,
    output logic [1:0]                           dtw_status
);

    localparam int LANES  = C_S_AXIS_TDATA_WIDTH / SAMPLE_WIDTH;
    localparam int BPL    = SAMPLE_WIDTH / 8;
    localparam int LANE_W = (LANES > 1) ? clogb2(LANES) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    state_e                               state_q, state_d;
    logic [LANES-1:0][SAMPLE_WIDTH-1:0]   data_q, data_d;
    logic [LANES-1:0]                     mask_q, mask_d;
    logic                                 tlast_q, tlast_d;
    logic [LANE_W-1:0]                    hi_q, hi_d;
    logic [LANE_W-1:0]                    lane_q, lane_d;
    logic [1:0]                           status_q, status_d;

    logic [LANES-1:0]   lane_valid_in, lane_partial_in;
    logic [LANE_W-1:0]  hi_in;
    logic               tready_int, handshake, wr_en, fifo_full, cur_valid, at_end;
    logic [SAMPLE_WIDTH:0] wr_data, rd_data;

    // A lane counts only when every one of its byte strobes is set.
    always_comb begin
        lane_valid_in   = '0;
        lane_partial_in = '0;
        hi_in           = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_valid_in[l]   = &S_AXIS_TSTRB[l*BPL +: BPL];
            lane_partial_in[l] = (|S_AXIS_TSTRB[l*BPL +: BPL]) && !lane_valid_in[l];
            if (lane_valid_in[l]) hi_in = LANE_W'(l);
        end
    end

    assign cur_valid = mask_q[lane_q];
    assign at_end    = (lane_q == LAST_LANE);
    assign handshake = S_AXIS_TVALID && tready_int && !S_AXIS_ARESET;

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        mask_d     = mask_q;
        tlast_d    = tlast_q;
        hi_d       = hi_q;
        lane_d     = lane_q;
        status_d   = status_q;
        tready_int = 1'b0;
        wr_en      = 1'b0;

        case (state_q)
            ST_IDLE: tready_int = 1'b1;
            ST_UNPACK: begin
                wr_en = cur_valid && !fifo_full;
                if (!cur_valid || !fifo_full) begin
                    if (at_end) begin
                        tready_int = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        lane_d = lane_q + LANE_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Accepting the next beat on the final lane keeps the stream back-to-back.
        if (handshake) begin
            if (|lane_partial_in) status_d[STAT_PARTIAL_LANE] = 1'b1;
            if (|lane_valid_in) begin
                data_d  = S_AXIS_TDATA;
                mask_d  = lane_valid_in;
                tlast_d = S_AXIS_TLAST;
                hi_d    = hi_in;
                lane_d  = '0;
                state_d = ST_UNPACK;
            end else begin
                if (S_AXIS_TLAST) status_d[STAT_NULL_LAST] = 1'b1;
                lane_d  = '0;
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
        if (S_AXIS_ARESET) begin
            state_q  <= ST_IDLE;
            data_q   <= '0;
            mask_q   <= '0;
            tlast_q  <= 1'b0;
            hi_q     <= '0;
            lane_q   <= '0;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            mask_q   <= mask_d;
            tlast_q  <= tlast_d;
            hi_q     <= hi_d;
            lane_q   <= lane_d;
            status_q <= status_d;
        end
    end

    assign wr_data = {tlast_q && (lane_q == hi_q), data_q[lane_q]};

    dtw_sample_fifo #(
        .WIDTH     (SAMPLE_WIDTH + 1),
        .DEPTH     (FIFO_DEPTH),
        .AF_MARGIN (ALMOST_FULL_MARGIN)
    ) u_fifo (
        .clk_i     (S_AXIS_ACLK),
        .rst_i     (S_AXIS_ARESET),
        .wr_en_i   (wr_en),
        .wr_data_i (wr_data),
        .rd_en_i   (dtw_fifo_rden),
        .rd_data_o (rd_data),
        .empty_o   (dtw_fifo_empty),
        .full_o    (fifo_full),
        .count_o   (dtw_fifo_count),
        .afull_o   (dtw_fifo_afull)
    );

    assign S_AXIS_TREADY = tready_int && !S_AXIS_ARESET;
    assign dtw_fifo_dout = rd_data[SAMPLE_WIDTH-1:0];
    assign dtw_fifo_last = rd_data[SAMPLE_WIDTH];
    assign dtw_status    = status_q;

endmodule

// File: tb/tb_dtw_axis_sample_unpacker.sv
// tb/tb_dtw_axis_sample_unpacker.sv - scoreboard bench for the AXI-Stream sample unpacker
module tb_dtw_axis_sample_unpacker;

    logic        clk = 1'b0;
    logic        rst;
    logic        tvalid, tlast, rden = 1'b0;
    logic [31:0] tdata;
    logic [3:0]  tstrb;
    logic        tready, last, empty, afull;
    logic [7:0]  dout;
    logic [4:0]  count;
    logic [1:0]  status;

    logic        tvalid16, tlast16;
    logic [31:0] tdata16;
    logic [3:0]  tstrb16;
    logic        tready16, last16, empty16, afull16;
    logic [15:0] dout16;
    logic [4:0]  count16;
    logic [1:0]  status16;

    int          vectors = 0;
    int          miscompares = 0;
    int          rd_credits = 0;
    int          pops = 0;
    logic [8:0]  sb [$];

    always #5 clk = ~clk;

    dtw_axis_sample_unpacker dut (
        .S_AXIS_ACLK    (clk),
        .S_AXIS_ARESET  (rst),
        .S_AXIS_TVALID  (tvalid),
        .S_AXIS_TREADY  (tready),
        .S_AXIS_TDATA   (tdata),
        .S_AXIS_TSTRB   (tstrb),
        .S_AXIS_TLAST   (tlast),
        .dtw_fifo_rden  (rden),
        .dtw_fifo_dout  (dout),
        .dtw_fifo_last  (last),
        .dtw_fifo_empty (empty),
        .dtw_fifo_count (count),
        .dtw_fifo_afull (afull),
        .dtw_status     (status)
    );

    dtw_axis_sample_unpacker #(.SAMPLE_WIDTH(16)) dut16 (
        .S_AXIS_ACLK    (clk),
        .S_AXIS_ARESET  (rst),
        .S_AXIS_TVALID  (tvalid16),
        .S_AXIS_TREADY  (tready16),
        .S_AXIS_TDATA   (tdata16),
        .S_AXIS_TSTRB   (tstrb16),
        .S_AXIS_TLAST   (tlast16),
        .dtw_fifo_rden  (1'b0),
        .dtw_fifo_dout  (dout16),
        .dtw_fifo_last  (last16),
        .dtw_fifo_empty (empty16),
        .dtw_fifo_count (count16),
        .dtw_fifo_afull (afull16),
        .dtw_status     (status16)
    );

    // Consumer: decides rden for the coming edge and checks the FWFT head it will pop.
    always @(negedge clk) begin
        logic [8:0] exp;
        if (!rst && rd_credits > 0 && empty === 1'b0) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_sample got last=%b dout=%h required=no_sample", last, dout);
            end else begin
                exp = sb.pop_front();
                if ({last, dout} !== exp)begin
                    miscompares++;
                    $display("FAIL sample_order got last=%b dout=%h required last=%b dout=%h",
                             last, dout, exp[8], exp[7:0]);
                end
            end
            rden = 1'b1;
            rd_credits--;
            pops++;
        end else begin
            rden = 1'b0;
        end
        if (!rst) begin
            vectors++;
            if (afull !== ((5'd16 - count) <= 5'd2)) begin
                miscompares++;
                $display("FAIL afull_threshold got afull=%b count=%0d required afull=%b",
                         afull, count, ((5'd16 - count) <= 5'd2));
            end
        end
    end

    task automatic send_beat(input logic [31:0] d, input logic [3:0] s, input logic l);
        int wait_n;
        int hi;
        @(negedge clk);
        tvalid = 1'b1; tdata = d; tstrb = s; tlast = l;
        wait_n = 0;
        while (tready !== 1'b1 && wait_n < 200) begin
            @(negedge clk);
            wait_n++;
        end
        vectors++;
        if (tready !== 1'b1) begin
            miscompares++;
            $display("FAIL handshake_timeout got tready=%b required=1", tready);
        end else begin
            hi = -1;
            for (int i = 0; i < 4; i++) if (s[i]) hi = i;
            for (int i = 0; i < 4; i++)
                if (s[i]) sb.push_back({l && (i == hi), d[i*8 +: 8]});
        end
        @(posedge clk);
    endtask

    task automatic drain();
        int wait_n;
        rd_credits = 1000000;
        wait_n = 0;
        while (!(sb.size() == 0 && empty === 1'b1) && wait_n < 500) begin
            @(negedge clk);
            wait_n++;
        end
        rd_credits = 0;
        vectors++;
        if (sb.size() != 0 || empty !== 1'b1) begin
            miscompares++;
            $display("FAIL drain got pending=%0d empty=%b required pending=0 empty=1", sb.size(), empty);
        end
    endtask

    task automatic check_reset_values(input string tag);
        vectors++;
        if ({tready, empty, count, afull, status, dout, last} !==
            {1'b0, 1'b1, 5'd0, 1'b0, 2'b00, 8'h00, 1'b0}) begin
            miscompares++;
            $display("FAIL %s got tready=%b empty=%b count=%0d afull=%b status=%b dout=%h last=%b required 0 1 0 0 00 00 0",
                     tag, tready, empty, count, afull, status, dout, last);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; tvalid = 1'b0; tdata = '0; tstrb = '0; tlast = 1'b0;
        tvalid16 = 1'b0; tdata16 = '0; tstrb16 = '0; tlast16 = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset_values");
        vectors++;
        if ({tready16, empty16, count16, afull16, status16, dout16, last16} !==
            {1'b0, 1'b1, 5'd0, 1'b0, 2'b00, 16'h0000, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_values16 got tready=%b empty=%b count=%0d status=%b required 0 1 0 00",
                     tready16, empty16, count16, status16);
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (tready !== 1'b1) begin
            miscompares++;
            $display("FAIL tready_after_reset got %b required 1", tready);
        end
    endtask

    task automatic test_single_beat();
        rd_credits = 0;
        send_beat(32'h44332211, 4'hF, 1'b1);
        @(negedge clk);
        tvalid = 1'b0;
        vectors++;
        if (count !== 5'd0) begin
            miscompares++;
            $display("FAIL single_latency got count=%0d required 0", count);
        end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            vectors++;
            if (count !== 5'(k)) begin
                miscompares++;
                $display("FAIL single_count got count=%0d required %0d", count, k);
            end
        end
        vectors++;
        if ({dout, last, afull} !== {8'h11, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL single_head got dout=%h last=%b afull=%b required 11 0 0", dout, last, afull);
        end
        drain();
    endtask

    task automatic test_sparse_strobe();
        send_beat(32'hDDCCBBAA, 4'h5, 1'b1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            tvalid = 1'b0;
            vectors++;
            if (tready !== (k == 3)) begin
                miscompares++;
                $display("FAIL sparse_tready cycle=%0d got %b required %b", k, tready, (k == 3));
            end
        end
        vectors++;
        if ({count, status} !== {5'd2, 2'b00}) begin
            miscompares++;
            $display("FAIL sparse_count got count=%0d status=%b required 2 00", count, status);
        end
        drain();
    endtask

    task automatic test_null_beat();
        int wait_n;
        send_beat(32'h12345678, 4'h0, 1'b1);
        @(negedge clk);
        tvalid = 1'b0;
        vectors++;
        if ({status, tready, count} !== {2'b10, 1'b1, 5'd0}) begin
            miscompares++;
            $display("FAIL null_beat got status=%b tready=%b count=%0d required 10 1 0", status, tready, count);
        end
        tvalid16 = 1'b1; tdata16 = 32'hCAFEBEEF; tstrb16 = 4'b0001; tlast16 = 1'b0;
        wait_n = 0;
        while (tready16 !== 1'b1 && wait_n < 50) begin
            @(negedge clk);
            wait_n++;
        end
        @(posedge clk);
        @(negedge clk);
        tvalid16 = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({status16, count16, empty16} !== {2'b01, 5'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL partial_lane16 got status=%b count=%0d empty=%b required 01 0 1", status16, count16, empty16);
        end
    endtask

    task automatic test_fill();
        rd_credits = 0;
        for (int b = 0; b < 5; b++)
            send_beat({8'(b*4+3), 8'(b*4+2), 8'(b*4+1), 8'(b*4)} | 32'h80808080, 4'hF, b == 4);
        @(negedge clk);
        tvalid = 1'b0;
        repeat (4) @(negedge clk);
        vectors++;
        if ({count, afull, tready} !== {5'd16, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL fill_full got count=%0d afull=%b tready=%b required 16 1 0", count, afull, tready);
        end
        rd_credits = 1;
        repeat (4) @(negedge clk);
        vectors++;
        if ({count, tready} !== {5'd16, 1'b0}) begin
            miscompares++;
            $display("FAIL fill_one_read got count=%0d tready=%b required 16 0", count, tready);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int max_count = 0;
        int pops_before;
        pops_before = pops;
        rd_credits = 1000000;
        fork
            begin
                for (int b = 0; b < 16; b++) send_beat($urandom(), 4'hF, b[0]);
                @(negedge clk);
                tvalid = 1'b0;
            end
            begin
                repeat (90) begin
                    @(negedge clk);
                    if (int'(count) > max_count) max_count = int'(count);
                end
            end
        join
        drain();
        vectors++;
        if (max_count > 1) begin
            miscompares++;
            $display("FAIL stream_occupancy got max=%0d required <=1", max_count);
        end
        vectors++;
        if (pops - pops_before != 64) begin
            miscompares++;
            $display("FAIL stream_pops got %0d required 64", pops - pops_before);
        end
    endtask

    task automatic test_reset_mid();
        rd_credits = 0;
        send_beat(32'h0F0E0D0C, 4'hF, 1'b1);
        @(negedge clk);
        tvalid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_values("async_reset");
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (tready !== 1'b1) begin
            miscompares++;
            $display("FAIL tready_after_mid_reset got %b required 1", tready);
        end
        send_beat(32'hA1B2C3D4, 4'hF, 1'b1);
        @(negedge clk);
        tvalid = 1'b0;
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_beat();
        test_sparse_strobe();
        test_null_beat();
        test_fill();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
